// File: rtl/teclado_pkg.sv
// Shared key codes, FSM state type and BCD helper for the keypad digit entry block.
package teclado_pkg;
  localparam logic [3:0] TECLA_NADA    = 4'hF;
  localparam logic [3:0] TECLA_ENTER   = 4'hE;
  localparam logic [3:0] TECLA_BORRAR  = 4'hD;
  localparam logic [3:0] TECLA_LIMPIAR = 4'hC;

  typedef enum logic [1:0] {REPOSO, REBOTE, PULSADO, SOLTANDO} estado_t;

  function automatic logic [9:0] bcd_a_bin(input logic [11:0] b);
    return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
  endfunction
endpackage

// File: rtl/ingreso_digitos_antirrebote.sv
// Row synchroniser, key presence window and press/release debounce FSM.
// Emits one tecla_valida pulse per physical press.
module antirrebote
  import teclado_pkg::*;
#(
  parameter int HOLD_CYC = 54_000,
  parameter int DEB_CYC  = 270_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  input  logic [3:0] boton,
  output logic [3:0] tecla,
  output logic       tecla_valida
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int DW = $clog2(DEB_CYC + 1);

  estado_t        estado_q, estado_d;
  logic [3:0]     f1_q, f2_q;
  logic [HW-1:0]  pres_q, pres_d;
  logic [DW-1:0]  deb_q, deb_d;
  logic [3:0]     codigo_q, codigo_d;
  logic [3:0]     tecla_q, tecla_d;
  logic           valida_q, valida_d;
  logic           fila_act, presente;

  // A scanner only drives one column at a time, so a row is seen low only
  // intermittently; the presence window bridges the gaps between visits.
  assign fila_act = (f2_q != TECLA_NADA);
  assign presente = (pres_q != '0) | fila_act;

  always_comb begin
    pres_d = pres_q;
    if (fila_act)            pres_d = HW'(HOLD_CYC - 1);
    else if (pres_q != '0)   pres_d = pres_q - 1'b1;
  end

  always_comb begin
    estado_d = estado_q;
    deb_d    = deb_q;
    codigo_d = codigo_q;
    tecla_d  = tecla_q;
    valida_d = 1'b0;
    case (estado_q)
      REPOSO: if (presente && boton != TECLA_NADA) begin
        codigo_d = boton;
        deb_d    = '0;
        estado_d = REBOTE;
      end
      REBOTE: begin
        if (!presente || boton != codigo_q) estado_d = REPOSO;
        else if (deb_q == DW'(DEB_CYC - 1)) begin
          estado_d = PULSADO;
          tecla_d  = codigo_q;
          valida_d = 1'b1;
        end else deb_d = deb_q + 1'b1;
      end
      PULSADO: if (!presente) begin
        estado_d = SOLTANDO;
        deb_d    = '0;
      end
      SOLTANDO: begin
        if (presente)                        deb_d = '0;
        else if (deb_q == DW'(DEB_CYC - 1))  estado_d = REPOSO;
        else                                 deb_d = deb_q + 1'b1;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      f1_q     <= '0;
      f2_q     <= '0;
      pres_q   <= '0;
      deb_q    <= '0;
      codigo_q <= '0;
      tecla_q  <= '0;
      valida_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      f1_q     <= filas;
      f2_q     <= f1_q;
      pres_q   <= pres_d;
      deb_q    <= deb_d;
      codigo_q <= codigo_d;
      tecla_q  <= tecla_d;
      valida_q <= valida_d;
    end
  end

  assign tecla        = tecla_q;
  assign tecla_valida = valida_q;
endmodule

// File: rtl/ingreso_digitos.sv
// Keypad digit entry: debounced key events feed a 3-digit BCD buffer committed by '#'.
// Optional BINARY_OUT_EN adds numero_bin, the binary value of the committed number.
module ingreso_digitos
  import teclado_pkg::*;
#(
  parameter int HOLD_CYC = 54_000,
  parameter int DEB_CYC  = 270_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  filas,
  input  logic [3:0]  boton,
  output logic [3:0]  tecla,
  output logic        tecla_valida,
  output logic [11:0] digitos_bcd,
  output logic [1:0]  num_digitos,
  output logic        lleno,
  output logic [11:0] numero_bcd,
  output logic        numero_valido
`ifdef BINARY_OUT_EN
  ,
  output logic [9:0]  numero_bin
`endif
);
  logic [11:0] ent_q, ent_d;
  logic [1:0]  n_q, n_d;
  logic [11:0] num_q, num_d;
  logic        nv_q, nv_d;

  antirrebote #(.HOLD_CYC(HOLD_CYC), .DEB_CYC(DEB_CYC)) u_antirrebote (
    .clk          (clk),
    .rst          (rst),
    .filas        (filas),
    .boton        (boton),
    .tecla        (tecla),
    .tecla_valida (tecla_valida)
  );

  always_comb begin
    ent_d = ent_q;
    n_d   = n_q;
    num_d = num_q;
    nv_d  = 1'b0;
    if (tecla_valida) begin
      if (tecla <= 4'd9) begin
        if (n_q != 2'd3) begin
          ent_d = {ent_q[7:0], tecla};
          n_d   = n_q + 1'b1;
        end
      end else begin
        case (tecla)
          TECLA_BORRAR: if (n_q != 2'd0) begin
            ent_d = {4'h0, ent_q[11:4]};
            n_d   = n_q - 1'b1;
          end
          TECLA_LIMPIAR: begin
            ent_d = '0;
            n_d   = '0;
          end
          TECLA_ENTER: if (n_q != 2'd0) begin
            num_d = ent_q;
            nv_d  = 1'b1;
            ent_d = '0;
            n_d   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      n_q   <= '0;
      num_q <= '0;
      nv_q  <= 1'b0;
    end else begin
      ent_q <= ent_d;
      n_q   <= n_d;
      num_q <= num_d;
      nv_q  <= nv_d;
    end
  end

`ifdef BINARY_OUT_EN
  logic [9:0] bin_q;
  always_ff @(posedge clk) begin
    if (rst)       bin_q <= '0;
    else if (nv_d) bin_q <= bcd_a_bin(ent_q);
  end
  assign numero_bin = bin_q;
`endif

  assign digitos_bcd   = ent_q;
  assign num_digitos   = n_q;
  assign lleno         = (n_q == 2'd3);
  assign numero_bcd    = num_q;
  assign numero_valido = nv_q;
endmodule

// File: tb/tb_ingreso_digitos.sv
// Directed bench for ingreso_digitos with short presence/debounce windows.
module tb_ingreso_digitos;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  filas, boton;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic [11:0] digitos_bcd, numero_bcd;
  logic [1:0]  num_digitos;
  logic        lleno, numero_valido;
`ifdef BINARY_OUT_EN
  logic [9:0]  numero_bin;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses, nvs, first_pulse;
  logic [3:0]  last_tecla;
  logic [11:0] last_num;

  always #5 clk = ~clk;

  ingreso_digitos #(.HOLD_CYC(8), .DEB_CYC(16)) dut (
    .clk(clk), .rst(rst), .filas(filas), .boton(boton),
    .tecla(tecla), .tecla_valida(tecla_valida),
    .digitos_bcd(digitos_bcd), .num_digitos(num_digitos), .lleno(lleno),
    .numero_bcd(numero_bcd), .numero_valido(numero_valido)
`ifdef BINARY_OUT_EN
    , .numero_bin(numero_bin)
`endif
  );

  task automatic clr();
    pulses = 0; nvs = 0; first_pulse = -1;
    last_tecla = 4'h0; last_num = 12'h0;
  endtask

  // mode 0 idle, 1 row low one cycle in four, 2 row held low, 3 row toggling every 3 cycles
  task automatic drive(input logic [3:0] key, input int ncyc, input int mode);
    for (int i = 0; i < ncyc; i++) begin
      boton = key;
      case (mode)
        1:       filas = (i % 4 == 0) ? 4'hE : 4'hF;
        2:       filas = 4'hE;
        3:       filas = ((i / 3) % 2 == 0) ? 4'hE : 4'hF;
        default: filas = 4'hF;
      endcase
      @(negedge clk);
      if (tecla_valida) begin
        pulses++; last_tecla = tecla;
        if (first_pulse < 0) first_pulse = i;
      end
      if (numero_valido) begin
        nvs++; last_num = numero_bcd;
      end
    end
  endtask

  task automatic press(input logic [3:0] key);
    drive(key, 40, 1);
    drive(4'hF, 40, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; boton = 4'hF; filas = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tecla, tecla_valida, digitos_bcd, num_digitos, lleno, numero_bcd, numero_valido} !== 35'h0) begin
      n_err++;
      $display("FAIL reset outputs: got tecla=%h v=%b dig=%h n=%0d lleno=%b num=%h nv=%b want all 0",
               tecla, tecla_valida, digitos_bcd, num_digitos, lleno, numero_bcd, numero_valido);
    end
    rst = 1'b0;
    clr();
    drive(4'hF, 20, 0);
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL idle_no_pulse: got %0d want 0", pulses); end
  endtask

  task automatic test_single_press();
    clr();
    press(4'h5);
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL press5_count: got %0d want 1", pulses); end
    n_cmp++;
    if (last_tecla !== 4'h5) begin n_err++; $display("FAIL press5_tecla: got %h want 5", last_tecla); end
    n_cmp++;
    if (first_pulse < 16 || first_pulse > 20) begin
      n_err++; $display("FAIL press5_latency: got %0d want 16..20", first_pulse);
    end
    n_cmp++;
    if (digitos_bcd !== 12'h005 || num_digitos !== 2'd1) begin
      n_err++; $display("FAIL press5_buffer: got %h/%0d want 005/1", digitos_bcd, num_digitos);
    end
  endtask

  task automatic test_bounce();
    clr();
    drive(4'hC, 12, 3);
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL bounce_quiet: got %0d want 0", pulses); end
    drive(4'hC, 40, 2);
    drive(4'hF, 40, 0);
    n_cmp++;
    if (pulses !== 1 || last_tecla !== 4'hC) begin
      n_err++; $display("FAIL bounce_single: got %0d pulses tecla=%h want 1 tecla=c", pulses, last_tecla);
    end
    n_cmp++;
    if (digitos_bcd !== 12'h000 || num_digitos !== 2'd0) begin
      n_err++; $display("FAIL clear_buffer: got %h/%0d want 000/0", digitos_bcd, num_digitos);
    end
  endtask

  task automatic test_full_enter();
    clr();
    press(4'h1); press(4'h2); press(4'h3);
    n_cmp++;
    if (digitos_bcd !== 12'h123 || lleno !== 1'b1) begin
      n_err++; $display("FAIL fill3: got %h lleno=%b want 123 lleno=1", digitos_bcd, lleno);
    end
    press(4'h4);
    n_cmp++;
    if (digitos_bcd !== 12'h123 || num_digitos !== 2'd3 || lleno !== 1'b1 || pulses !== 4) begin
      n_err++; $display("FAIL full_ignore: got %h n=%0d lleno=%b pulses=%0d want 123 3 1 4",
                        digitos_bcd, num_digitos, lleno, pulses);
    end
    press(4'hE);
    n_cmp++;
    if (nvs !== 1 || last_num !== 12'h123 || numero_bcd !== 12'h123) begin
      n_err++; $display("FAIL enter123: got nv=%0d num=%h want 1 123", nvs, numero_bcd);
    end
    n_cmp++;
    if (digitos_bcd !== 12'h000 || num_digitos !== 2'd0 || lleno !== 1'b0) begin
      n_err++; $display("FAIL enter_clears: got %h n=%0d lleno=%b want 000 0 0", digitos_bcd, num_digitos, lleno);
    end
`ifdef BINARY_OUT_EN
    n_cmp++;
    if (numero_bin !== 10'd123) begin n_err++; $display("FAIL bin123: got %0d want 123", numero_bin); end
`endif
  endtask

  task automatic test_delete();
    clr();
    press(4'h7); press(4'h8); press(4'hD);
    n_cmp++;
    if (digitos_bcd !== 12'h007 || num_digitos !== 2'd1) begin
      n_err++; $display("FAIL delete: got %h/%0d want 007/1", digitos_bcd, num_digitos);
    end
    press(4'h9); press(4'hE);
    n_cmp++;
    if (nvs !== 1 || numero_bcd !== 12'h079) begin
      n_err++; $display("FAIL enter079: got nv=%0d num=%h want 1 079", nvs, numero_bcd);
    end
    clr();
    press(4'hE);
    n_cmp++;
    if (nvs !== 0 || pulses !== 1 || numero_bcd !== 12'h079) begin
      n_err++; $display("FAIL empty_enter: got nv=%0d pulses=%0d num=%h want 0 1 079", nvs, pulses, numero_bcd);
    end
  endtask

  task automatic test_clear_op();
    clr();
    press(4'h4); press(4'h2); press(4'hC);
    n_cmp++;
    if (digitos_bcd !== 12'h000 || num_digitos !== 2'd0) begin
      n_err++; $display("FAIL clear42: got %h/%0d want 000/0", digitos_bcd, num_digitos);
    end
    clr();
    press(4'hA);
    n_cmp++;
    if (pulses !== 1 || last_tecla !== 4'hA || nvs !== 0 || digitos_bcd !== 12'h000) begin
      n_err++; $display("FAIL key_a: got pulses=%0d tecla=%h nv=%0d dig=%h want 1 a 0 000",
                        pulses, last_tecla, nvs, digitos_bcd);
    end
  endtask

  task automatic test_reset_midpress();
    clr();
    drive(4'h9, 30, 2);
    n_cmp++;
    if (pulses !== 1 || digitos_bcd !== 12'h009) begin
      n_err++; $display("FAIL hold9: got pulses=%0d dig=%h want 1 009", pulses, digitos_bcd);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tecla, tecla_valida, digitos_bcd, num_digitos, lleno, numero_bcd, numero_valido} !== 35'h0) begin
      n_err++; $display("FAIL midpress_reset: got tecla=%h dig=%h num=%h n=%0d want all 0",
                        tecla, digitos_bcd, numero_bcd, num_digitos);
    end
    rst = 1'b0;
    clr();
    drive(4'h9, 40, 2);
    drive(4'hF, 40, 0);
    n_cmp++;
    if (pulses !== 1 || last_tecla !== 4'h9 || digitos_bcd !== 12'h009) begin
      n_err++; $display("FAIL redetect: got pulses=%0d tecla=%h dig=%h want 1 9 009", pulses, last_tecla, digitos_bcd);
    end
  endtask

`ifdef BINARY_OUT_EN
  task automatic test_binary();
    clr();
    press(4'hC); press(4'h9); press(4'h9); press(4'h9); press(4'hE);
    n_cmp++;
    if (numero_bcd !== 12'h999 || numero_bin !== 10'd999) begin
      n_err++; $display("FAIL bin999: got %h/%0d want 999/999", numero_bcd, numero_bin);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_full_enter();
    test_delete();
    test_clear_op();
    test_reset_midpress();
`ifdef BINARY_OUT_EN
    test_binary();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
